// File: rtl/spi_sclk_gen_if.sv
// Handshake and clock/strobe bundle between an SPI master datapath and its SCLK/CS generator.
// The master modport drives requests; the slave modport is the generator side.
interface spi_sclk_gen_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             cs_n;
    logic             sclk;
    logic             sample_pulse;
    logic             shift_pulse;
    logic [IDX_W-1:0] bit_idx;

    modport master (
        output start, abort,
        input  busy, done, cs_n, sclk, sample_pulse, shift_pulse, bit_idx
    );

    modport slave (
        input  start, abort,
        output busy, done, cs_n, sclk, sample_pulse, shift_pulse, bit_idx
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI master SCLK / chip-select generator with per-edge sample and shift strobes.
// Sequence IDLE -> SETUP -> RUN -> HOLD, each step spaced CLK_DIV clocks apart.
module spi_sclk_gen #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_sclk_gen_if.slave   bus
);
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam int IDX_W  = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        HOLD
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [EDGE_W-1:0]   edge_cnt_q;
    logic [EDGE_W-1:0]   edge_cnt_d;
    logic [IDX_W-1:0]    bit_idx_q;
    logic                busy_q;
    logic                done_q;
    logic                cs_n_q;
    logic                sclk_q;
    logic                sample_q;
    logic                shift_q;
    logic                half_done;
    logic                leading;
    logic                last_edge;

    // edge_cnt_d is the number of the edge about to be made; odd numbers are leading edges.
    always_comb begin
        edge_cnt_d = edge_cnt_q + 1'b1;
        half_done  = (cnt_q == CNT_W'(CLK_DIV - 1));
        leading    = edge_cnt_d[0];
        last_edge  = (edge_cnt_d == EDGE_W'(2 * DATA_WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            bit_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= CPOL;
            sample_q   <= 1'b0;
            shift_q    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle and are raised only where an
            // edge is made; non-blocking assignment lets later branches override them.
            done_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            if (sample_q) begin
                bit_idx_q <= bit_idx_q + 1'b1;
            end

            if (state_q != IDLE && bus.abort) begin
                state_q <= IDLE;
                cs_n_q  <= 1'b1;
                sclk_q  <= CPOL;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state_q    <= SETUP;
                            cs_n_q     <= 1'b0;
                            busy_q     <= 1'b1;
                            cnt_q      <= '0;
                            edge_cnt_q <= '0;
                            bit_idx_q  <= '0;
                        end
                    end
                    SETUP, RUN: begin
                        if (half_done) begin
                            cnt_q      <= '0;
                            sclk_q     <= ~sclk_q;
                            edge_cnt_q <= edge_cnt_d;
                            sample_q   <= CPHA ? !leading : leading;
                            // With CPHA=0 the first MOSI bit is already out at cs_n fall,
                            // so the final trailing edge carries no shift.
                            shift_q    <= CPHA ? leading : (!leading && !last_edge);
                            state_q    <= last_edge ? HOLD : RUN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (half_done) begin
                            state_q <= IDLE;
                            cs_n_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cs_n         = cs_n_q;
    assign bus.sclk         = sclk_q;
    assign bus.sample_pulse = sample_q;
    assign bus.shift_pulse  = shift_q;
    assign bus.bit_idx      = bit_idx_q;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// Scoreboard bench: three generator configurations; each finished cs_n window is
// summarised by a monitor and compared against a queued hand-computed expectation.
module tb_spi_sclk_gen;
    localparam int CD_P   [3] = '{2, 3, 2};
    localparam int DW_P   [3] = '{8, 8, 1};
    localparam bit CPOL_P [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit CPHA_P [3] = '{1'b0, 1'b1, 1'b0};

    typedef struct {
        int cs_low;
        int edges;
        int samples;
        int shifts;
        int idx_end;
        int done;
        int gap;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] abort_v;
    logic [2:0] busy_v, done_v, cs_n_v, sclk_v, samp_v, shift_v;
    int         idx_v [3];

    rec_t exp_q [3][$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   end_req = 1'b0;
    bit   end_ack = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        spi_sclk_gen_if #(.DATA_WIDTH(DW_P[g])) bus ();

        spi_sclk_gen #(
            .CLK_DIV   (CD_P[g]),
            .DATA_WIDTH(DW_P[g]),
            .CPOL      (CPOL_P[g]),
            .CPHA      (CPHA_P[g])
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus.slave)
        );

        assign bus.start  = start_v[g];
        assign bus.abort  = abort_v[g];
        assign busy_v[g]  = bus.busy;
        assign done_v[g]  = bus.done;
        assign cs_n_v[g]  = bus.cs_n;
        assign sclk_v[g]  = bus.sclk;
        assign samp_v[g]  = bus.sample_pulse;
        assign shift_v[g] = bus.shift_pulse;
        assign idx_v[g]   = int'(bus.bit_idx);
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic rec_t mk(int cs_low, int edges, int samples, int shifts,
                                int idx_end, int done, int gap);
        rec_t r;
        r.cs_low  = cs_low;
        r.edges   = edges;
        r.samples = samples;
        r.shifts  = shifts;
        r.idx_end = idx_end;
        r.done    = done;
        r.gap     = gap;
        return r;
    endfunction

    // ---------------- monitor ----------------
    bit prev_cs [3], prev_sclk [3], in_txn [3], rst_seen [3];
    int t_c [3], low_c [3], edges_c [3], samp_c [3], shift_c [3];
    int last_t [3], idx0_c [3], gap_rec [3], gap_cnt [3], bad_c [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                if (!rst_seen[i]) begin
                    check($sformatf("reset_ctl[%0d]", i),
                          int'({busy_v[i], done_v[i], cs_n_v[i], sclk_v[i], samp_v[i], shift_v[i]}),
                          int'({1'b0, 1'b0, 1'b1, CPOL_P[i], 1'b0, 1'b0}));
                    check($sformatf("reset_idx[%0d]", i), idx_v[i], 0);
                    rst_seen[i] = 1'b1;
                end
                in_txn[i]    = 1'b0;
                gap_cnt[i]   = -1;
                prev_cs[i]   = cs_n_v[i];
                prev_sclk[i] = sclk_v[i];
            end else begin
                bit cs, sc, chg;
                rst_seen[i] = 1'b0;
                cs  = cs_n_v[i];
                sc  = sclk_v[i];
                chg = (sc != prev_sclk[i]);
                // Structural rules checked every cycle; any breach poisons the next record.
                if (busy_v[i] == cs)                  bad_c[i]++;
                if (cs && sc != CPOL_P[i])            bad_c[i]++;
                if (samp_v[i] && !(chg && sc))        bad_c[i]++;
                if (shift_v[i] && !(chg && !sc))      bad_c[i]++;
                if (done_v[i] && !(cs && !prev_cs[i])) bad_c[i]++;

                if (!cs && prev_cs[i]) begin
                    in_txn[i]  = 1'b1;
                    t_c[i]     = 0;
                    low_c[i]   = 1;
                    edges_c[i] = 0;
                    samp_c[i]  = 0;
                    shift_c[i] = 0;
                    last_t[i]  = 0;
                    idx0_c[i]  = idx_v[i];
                    gap_rec[i] = gap_cnt[i];
                end else if (!cs && in_txn[i]) begin
                    t_c[i]++;
                    low_c[i]++;
                end

                if (!cs && in_txn[i]) begin
                    if (chg) begin
                        edges_c[i]++;
                        if (t_c[i] - last_t[i] != CD_P[i]) bad_c[i]++;
                        last_t[i] = t_c[i];
                    end
                    if (samp_v[i])  samp_c[i]++;
                    if (shift_v[i]) shift_c[i]++;
                end

                if (cs && !prev_cs[i] && in_txn[i]) begin
                    in_txn[i] = 1'b0;
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_txn[%0d]", i), 1, 0);
                    end else begin
                        rec_t e;
                        e = exp_q[i].pop_front();
                        check($sformatf("cs_low_len[%0d]", i), low_c[i], e.cs_low);
                        check($sformatf("sclk_edges[%0d]", i), edges_c[i], e.edges);
                        check($sformatf("sample_cnt[%0d]", i), samp_c[i], e.samples);
                        check($sformatf("shift_cnt[%0d]", i), shift_c[i], e.shifts);
                        check($sformatf("bit_idx_end[%0d]", i), idx_v[i], e.idx_end);
                        check($sformatf("done_at_end[%0d]", i), int'(done_v[i]), e.done);
                        check($sformatf("bit_idx_start[%0d]", i), idx0_c[i], 0);
                        check($sformatf("rule_breaches[%0d]", i), bad_c[i], 0);
                        if (e.gap >= 0) check($sformatf("cs_gap[%0d]", i), gap_rec[i], e.gap);
                    end
                    gap_cnt[i] = 1;
                end else if (cs && gap_cnt[i] >= 0) begin
                    gap_cnt[i]++;
                end
                prev_cs[i]   = cs;
                prev_sclk[i] = sc;
            end
        end
        if (end_req && !end_ack) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("leftover_expect[%0d]", i), exp_q[i].size(), 0);
                check($sformatf("final_breaches[%0d]", i), bad_c[i], 0);
            end
            end_ack = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        tick(1);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        for (int c = 0; c < 400 && busy_v[i]; c++) tick(1);
        tick(3);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        abort_v = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Mode 0, CLK_DIV=2: 34-clk window; a start pulse mid-transaction is ignored.
        exp_q[0].push_back(mk(34, 16, 8, 7, 8, 1, -1));
        pulse_start(0);
        tick(10);
        pulse_start(0);
        wait_idle(0);

        // Mode 3, CLK_DIV=3: 51-clk window, 8 shifts on falling and 8 samples on rising edges.
        exp_q[1].push_back(mk(51, 16, 8, 8, 8, 1, -1));
        pulse_start(1);
        wait_idle(1);

        // DATA_WIDTH=1: 6-clk window, 2 edges, 1 sample, no shift.
        exp_q[2].push_back(mk(6, 2, 1, 0, 1, 1, -1));
        pulse_start(2);
        wait_idle(2);

        // start held high: three back-to-back windows with a 1-clk cs_n-high gap.
        exp_q[0].push_back(mk(34, 16, 8, 7, 8, 1, -1));
        exp_q[0].push_back(mk(34, 16, 8, 7, 8, 1, 1));
        exp_q[0].push_back(mk(34, 16, 8, 7, 8, 1, 1));
        begin
            int  rises = 0;
            bit  prev_busy = 1'b0;
            start_v[0] = 1'b1;
            for (int c = 0; c < 300 && rises < 3; c++) begin
                tick(1);
                if (busy_v[0] && !prev_busy) rises++;
                prev_busy = busy_v[0];
            end
            start_v[0] = 1'b0;
        end
        wait_idle(0);

        // abort during cycle t0+7: edges at t0+2/4/6 made, window ends at t0+8, no done.
        exp_q[0].push_back(mk(8, 3, 2, 1, 2, 0, -1));
        pulse_start(0);
        tick(7);
        abort_v[0] = 1'b1;
        tick(1);
        abort_v[0] = 1'b0;
        wait_idle(0);
        exp_q[0].push_back(mk(34, 16, 8, 7, 8, 1, -1));
        pulse_start(0);
        wait_idle(0);

        // abort while idle, then abort together with start: nothing may happen.
        abort_v[2] = 1'b1;
        tick(1);
        abort_v[2] = 1'b0;
        tick(2);
        start_v[2] = 1'b1;
        abort_v[2] = 1'b1;
        tick(1);
        start_v[2] = 1'b0;
        abort_v[2] = 1'b0;
        tick(10);
        exp_q[2].push_back(mk(6, 2, 1, 0, 1, 1, -1));
        pulse_start(2);
        wait_idle(2);

        // Asynchronous reset during cycle t0+5, then a clean transaction.
        pulse_start(1);
        tick(5);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        exp_q[1].push_back(mk(51, 16, 8, 8, 8, 1, -1));
        pulse_start(1);
        wait_idle(1);

        end_req = 1'b1;
        for (int c = 0; c < 10 && !end_ack; c++) tick(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
